// File: rtl/router_pkg.sv
// ============================================================================
//  Module   : router_pkg
//  Purpose  : Shared types and constants for the router RX datapath.
//             - wr_state_t : write-side FSM state of the frame FIFO
//             - beat_t     : one stored stream beat {tlast, tdata}
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package router_pkg;

    localparam int c_DEFAULT_DATA_W = 8;

    typedef enum logic [0:0] {
        ACCEPT = 1'b0,
        DROP   = 1'b1
    } wr_state_t;

    typedef struct packed {
        logic                        tlast;
        logic [c_DEFAULT_DATA_W-1:0] tdata;
    } beat_t;

endpackage

`default_nettype wire

// File: rtl/rff_sdp_ram.sv
// ============================================================================
//  Module   : rff_sdp_ram
//  Purpose  : Simple dual-port RAM, one write port, one registered read port.
//             The array itself carries no reset.
//  Ports    : clk        - clock
//             wr_en_i    - write enable
//             wr_addr_i  - write address
//             wr_data_i  - write data
//             rd_en_i    - read enable (output register loads when high)
//             rd_addr_i  - read address
//             rd_data_o  - registered read data, holds while rd_en_i is low
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rff_sdp_ram #(
    parameter int WIDTH  = 9,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem [2**ADDR_W];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

`default_nettype wire

// File: rtl/rx_frame_fifo.sv
// ============================================================================
//  Module   : rx_frame_fifo
//  Purpose  : Store-and-forward AXI-Stream frame FIFO. Only complete,
//             error-free frames become visible to the consumer; errored or
//             overflowing frames are discarded by rewinding the write pointer.
//  Ports    : clk, resetn                 - clock, async active-low reset
//             s_tdata/tvalid/tready/tlast/tuser - input stream (never stalls)
//             m_tdata/tvalid/tready/tlast - output stream
//             drop_pulse                  - one-cycle pulse per dropped frame
//             ok_cnt, drop_cnt            - wrapping frame statistics
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rx_frame_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 11,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    input  logic              s_tlast,
    input  logic              s_tuser,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              drop_pulse,
    output logic [CNT_W-1:0]  ok_cnt,
    output logic [CNT_W-1:0]  drop_cnt
);

    import router_pkg::*;

    localparam logic [DEPTH_LOG2-1:0] c_PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]      c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    wr_state_t              state_q, state_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  wr_commit_q, wr_commit_d;
    logic [DEPTH_LOG2-1:0]  commit_rd_q;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q;
    logic                   s_tready_q;
    logic                   m_tvalid_q;
    logic                   drop_pulse_q;
    logic [CNT_W-1:0]       ok_cnt_q, drop_cnt_q;

    logic                   w_beat;
    logic                   w_full;
    logic [DEPTH_LOG2-1:0]  w_wr_ptr_inc;
    logic                   w_wr_en;
    logic                   w_ok_inc;
    logic                   w_drop_inc;
    logic                   w_frame_avail;
    logic                   w_rd_en;
    logic [DATA_W:0]        w_ram_rdata;

    assign w_beat       = s_tvalid & s_tready_q;
    assign w_wr_ptr_inc = wr_ptr_q + c_PTR_ONE;
    // One slot is kept free so that wr_ptr == rd_ptr always means empty.
    assign w_full       = (w_wr_ptr_inc == rd_ptr_q);

    // ------------------------------------------------------------------
    // Write FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ACCEPT;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Write FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCEPT:  if (w_beat && w_full && !s_tlast) state_d = DROP;
            DROP:    if (w_beat && s_tlast)            state_d = ACCEPT;
            default: state_d = ACCEPT;
        endcase
    end

    // ------------------------------------------------------------------
    // Write FSM: outputs (RAM write, pointer moves, statistics strobes)
    // ------------------------------------------------------------------
    always_comb begin
        w_wr_en     = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        wr_commit_d = wr_commit_q;
        w_ok_inc    = 1'b0;
        w_drop_inc  = 1'b0;
        case (state_q)
            ACCEPT: begin
                if (w_beat) begin
                    if (!w_full) begin
                        if (!s_tlast) begin
                            w_wr_en  = 1'b1;
                            wr_ptr_d = w_wr_ptr_inc;
                        end else if (!s_tuser) begin
                            w_wr_en     = 1'b1;
                            wr_ptr_d    = w_wr_ptr_inc;
                            wr_commit_d = w_wr_ptr_inc;
                            w_ok_inc    = 1'b1;
                        end else begin
                            // Errored frame: forget everything since last commit.
                            wr_ptr_d   = wr_commit_q;
                            w_drop_inc = 1'b1;
                        end
                    end else begin
                        // Overflow: rewind now; the drop is counted on tlast,
                        // either right here or later from DROP.
                        wr_ptr_d   = wr_commit_q;
                        w_drop_inc = s_tlast;
                    end
                end
            end
            DROP: begin
                // wr_ptr was already rewound on entry.
                w_drop_inc = w_beat & s_tlast;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Write-side registers and statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s_tready_q   <= 1'b0;
            wr_ptr_q     <= '0;
            wr_commit_q  <= '0;
            commit_rd_q  <= '0;
            drop_pulse_q <= 1'b0;
            ok_cnt_q     <= '0;
            drop_cnt_q   <= '0;
        end else begin
            s_tready_q   <= 1'b1;
            wr_ptr_q     <= wr_ptr_d;
            wr_commit_q  <= wr_commit_d;
            // Read side sees the commit one cycle later, so a freshly
            // committed frame is first read the cycle after its commit.
            commit_rd_q  <= wr_commit_q;
            drop_pulse_q <= w_drop_inc;
            if (w_ok_inc)   ok_cnt_q   <= ok_cnt_q + c_CNT_ONE;
            if (w_drop_inc) drop_cnt_q <= drop_cnt_q + c_CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Read side: the RAM output register acts as the output stage.
    // It only reloads on w_rd_en, so data holds while the consumer stalls.
    // ------------------------------------------------------------------
    assign w_frame_avail = (rd_ptr_q != commit_rd_q);
    assign w_rd_en       = w_frame_avail & (~m_tvalid_q | m_tready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_q   <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            if (w_rd_en) begin
                rd_ptr_q   <= rd_ptr_q + c_PTR_ONE;
                m_tvalid_q <= 1'b1;
            end else if (m_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    rff_sdp_ram #(
        .WIDTH  (DATA_W + 1),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (w_wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i ({s_tlast, s_tdata}),
        .rd_en_i   (w_rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (w_ram_rdata)
    );

    // The RAM output register has no reset; mask it until a beat is loaded.
    assign {m_tlast, m_tdata} = m_tvalid_q ? w_ram_rdata : '0;

    assign s_tready   = s_tready_q;
    assign m_tvalid   = m_tvalid_q;
    assign drop_pulse = drop_pulse_q;
    assign ok_cnt     = ok_cnt_q;
    assign drop_cnt   = drop_cnt_q;

endmodule

`default_nettype wire
